// File: rtl/tinyalu_ctrl_pkg.sv
// Shared types and op decode for the tinyalu requester arbiter.
package tinyalu_ctrl_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned RES_W  = 16;

  typedef enum logic [OP_W-1:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100
  } operation_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_cmd_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return op <= OP_W'(mul_op);
  endfunction

  // Legal ops that actually need the ALU (everything except no_op).
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op != OP_W'(no_op)) && is_legal_op(op);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; the tie-break pointer moves only on update.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant_c
);

  logic prio_q;  // 1: requester 1 wins a tie

  always_comb begin
    grant_c = req;
    if (req == 2'b11) grant_c = prio_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    prio_q <= 1'b0;
    else if (update) prio_q <= grant_c[0];
  end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Shares one tinyalu between two valid/ready requesters with local no_op/illegal
// handling, a start watchdog and a post-operation drain of the done pipeline.
module tinyalu_arbiter
  import tinyalu_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_W-1:0]   req0_a,
  input  logic [DATA_W-1:0]   req0_b,
  input  logic [OP_W-1:0]     req0_op,
  output logic                rsp0_valid,
  output logic [RES_W-1:0]    rsp0_result,
  output logic                rsp0_err,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_W-1:0]   req1_a,
  input  logic [DATA_W-1:0]   req1_b,
  input  logic [OP_W-1:0]     req1_op,
  output logic                rsp1_valid,
  output logic [RES_W-1:0]    rsp1_result,
  output logic                rsp1_err,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_op,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic [RES_W-1:0]    alu_result,
  output logic                busy
);

  localparam int unsigned TO_W = $clog2(TIMEOUT);
  localparam int unsigned DR_W = $clog2(DRAIN);

  state_t           state;
  logic [TO_W-1:0]  to_cnt;
  logic [DR_W-1:0]  dr_cnt;
  logic             owner;
  logic             issued;
  logic [RES_W-1:0] res_q;
  logic             err_q;
  logic [1:0]       grant_c;
  logic             accept_c;
  alu_cmd_t         sel_c;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({req1_valid, req0_valid}),
    .update  (accept_c),
    .grant_c (grant_c)
  );

  assign req0_ready  = grant_c[0] && (state == IDLE);
  assign req1_ready  = grant_c[1] && (state == IDLE);
  assign accept_c    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;

  // Payload of the granted requester.
  always_comb begin
    sel_c = '{a: req0_a, b: req0_b, op: req0_op};
    if (grant_c[1]) sel_c = '{a: req1_a, b: req1_b, op: req1_op};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      to_cnt     <= '0;
      dr_cnt     <= '0;
      owner      <= 1'b0;
      issued     <= 1'b0;
      res_q      <= '0;
      err_q      <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            owner  <= grant_c[1];
            busy   <= 1'b1;
            to_cnt <= '0;
            if (is_alu_op(sel_c.op)) begin
              alu_a     <= sel_c.a;
              alu_b     <= sel_c.b;
              alu_op    <= sel_c.op;
              alu_start <= 1'b1;
              issued    <= 1'b1;
              state     <= ISSUE;
            end else begin
              // Answered locally; the ALU never sees it.
              res_q      <= '0;
              err_q      <= !is_legal_op(sel_c.op);
              issued     <= 1'b0;
              rsp0_valid <= grant_c[0];
              rsp1_valid <= grant_c[1];
              state      <= RESP;
            end
          end
        end
        ISSUE: begin
          if (alu_done) begin
            res_q      <= alu_result;
            err_q      <= 1'b0;
            alu_start  <= 1'b0;
            rsp0_valid <= !owner;
            rsp1_valid <= owner;
            state      <= RESP;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            res_q      <= '0;
            err_q      <= 1'b1;
            alu_start  <= 1'b0;
            rsp0_valid <= !owner;
            rsp1_valid <= owner;
            state      <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: begin
          dr_cnt <= '0;
          if (issued) begin
            state <= tinyalu_ctrl_pkg::DRAIN;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        tinyalu_ctrl_pkg::DRAIN: begin
          // alu_done is ignored here: the multiplier re-pulses done after start drops.
          if (dr_cnt == DR_W'(DRAIN - 1)) begin
            alu_op <= '0;
            state  <= IDLE;
            busy   <= 1'b0;
          end else begin
            dr_cnt <= dr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Self-checking bench: transaction-level model of the arbiter plus a latency-programmable ALU stand-in.
module tb_tinyalu_arbiter;

  localparam int unsigned DRAIN   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [1:0]  rv;
  logic [7:0]  ra [2];
  logic [7:0]  rb [2];
  logic [2:0]  ro [2];
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [15:0] rsp0_result, rsp1_result, alu_result;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_start, alu_done, busy;

  tinyalu_arbiter #(.DRAIN(DRAIN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_a(ra[0]), .req0_b(rb[0]), .req0_op(ro[0]),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
    .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_a(ra[1]), .req1_b(rb[1]), .req1_op(ro[1]),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
  );

  // What a tinyalu computes for each op.
  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // ALU stand-in: done after 'lat' start cycles; random done noise while start is low.
  int unsigned lat;
  int unsigned sc;
  logic        noise;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) sc <= 0;
    else          sc <= alu_start ? sc + 1 : 0;
  assign alu_done   = alu_start ? (sc == lat) : noise;
  assign alu_result = alu_ref(alu_a, alu_b, alu_op);

  // Model state
  int cyc, free_at, st_from, st_to, rsp_cyc, rsp_who, prio, acc_cyc;
  logic [15:0] exp_res;
  logic        exp_err;
  logic [7:0]  cur_a, cur_b;
  logic [2:0]  cur_op;
  logic        pv [2];
  logic [7:0]  pa [2];
  logic [7:0]  pb [2];
  logic [2:0]  po [2];
  bit auto_gen, auto_lat, noise_en;

  // Observations of the DUT
  int seen_cyc, seen_who, rsp_count, start_seen, busy_seen;
  logic [15:0] seen_res;
  logic        seen_err;
  int dut_grants[$];

  int vectors, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    free_at = 0; st_from = 0; st_to = -1; rsp_cyc = -1; rsp_who = 0; prio = 0;
    pv[0] = 1'b0; pv[1] = 1'b0;
  endtask

  task automatic accept(input int g);
    int d;
    logic [2:0] op;
    op = po[g];
    acc_cyc = cyc; prio = 1 - g; pv[g] = 1'b0; rsp_who = g;
    if (op == 3'd0 || op > 3'd4) begin
      rsp_cyc = cyc + 1; exp_res = 16'h0000; exp_err = (op > 3'd4); free_at = cyc + 2;
    end else begin
      cur_a = pa[g]; cur_b = pb[g]; cur_op = op;
      if (auto_lat) begin
        case ($urandom_range(0, 8))
          0, 1, 2: lat = 1;
          3, 4:    lat = 4;
          5:       lat = 0;
          6:       lat = TIMEOUT - 1;
          7:       lat = TIMEOUT;
          default: lat = 1000;
        endcase
      end
      if (lat + 1 <= TIMEOUT) begin
        d = cyc + 1 + int'(lat); exp_res = alu_ref(cur_a, cur_b, op); exp_err = 1'b0;
      end else begin
        d = cyc + int'(TIMEOUT); exp_res = 16'h0000; exp_err = 1'b1;
      end
      st_from = cyc + 1; st_to = d; rsp_cyc = d + 1; free_at = d + 2 + int'(DRAIN);
    end
  endtask

  // One clock cycle: drive, compare against the model, observe, advance the model.
  task automatic step();
    int g;
    bit idle, st;
    @(negedge clk);
    cyc++;
    for (int r = 0; r < 2; r++) begin
      if (auto_gen && !pv[r] && $urandom_range(0, 2) == 0) begin
        pv[r] = 1'b1; pa[r] = 8'($urandom); pb[r] = 8'($urandom); po[r] = 3'($urandom_range(0, 7));
      end
      rv[r] = pv[r];
      ra[r] = pv[r] ? pa[r] : 8'($urandom);
      rb[r] = pv[r] ? pb[r] : 8'($urandom);
      ro[r] = pv[r] ? po[r] : 3'($urandom);
    end
    noise = noise_en && ($urandom_range(0, 1) == 1);
    #1;
    idle = (cyc >= free_at);
    g = -1;
    if (idle) begin
      if (pv[0] && pv[1]) g = prio;
      else if (pv[0])     g = 0;
      else if (pv[1])     g = 1;
    end
    st = (cyc >= st_from) && (cyc <= st_to);
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    chk("busy", 32'(busy), 32'(!idle));
    chk("alu_start", 32'(alu_start), 32'(st));
    if (st) begin
      chk("alu_a", 32'(alu_a), 32'(cur_a));
      chk("alu_b", 32'(alu_b), 32'(cur_b));
      chk("alu_op", 32'(alu_op), 32'(cur_op));
    end
    if (idle) chk("alu_op_idle", 32'(alu_op), 32'(0));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(cyc == rsp_cyc && rsp_who == 0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(cyc == rsp_cyc && rsp_who == 1));
    if (cyc == rsp_cyc) begin
      chk("rsp_result", 32'(rsp_who == 0 ? rsp0_result : rsp1_result), 32'(exp_res));
      chk("rsp_err", 32'(rsp_who == 0 ? rsp0_err : rsp1_err), 32'(exp_err));
    end
    if (rsp0_valid) begin seen_cyc = cyc; seen_who = 0; seen_res = rsp0_result; seen_err = rsp0_err; rsp_count++; end
    if (rsp1_valid) begin seen_cyc = cyc; seen_who = 1; seen_res = rsp1_result; seen_err = rsp1_err; rsp_count++; end
    if (alu_start) start_seen++;
    if (busy) busy_seen++;
    if (req0_ready && rv[0]) dut_grants.push_back(0);
    if (req1_ready && rv[1]) dut_grants.push_back(1);
    if (g >= 0) accept(g);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      step();
      if (cyc >= free_at && !pv[0] && !pv[1]) done = 1'b1;
    end
    vectors++;
    if (!done) begin
      errors++;
      $display("FAIL wait_idle cyc=%0d actual=busy required=idle", cyc);
    end
  endtask

  task automatic issue(input int r, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    pv[r] = 1'b1; pa[r] = a; pb[r] = b; po[r] = op;
    rsp_count = 0; start_seen = 0; busy_seen = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int rem [2];
    int t0;
    vectors = 0; errors = 0; cyc = 0;
    auto_gen = 0; auto_lat = 0; noise_en = 0; noise = 0; lat = 1;
    rv = 2'b00;
    for (int r = 0; r < 2; r++) begin ra[r] = '0; rb[r] = '0; ro[r] = '0; end
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_alu_start", 32'(alu_start), 32'(0));
    chk("reset_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'(0));
    chk("reset_alu_op", 32'(alu_op), 32'(0));
    reset_n = 1'b1;

    // add 12+34 on requester 0
    issue(0, 8'h12, 8'h34, 3'd1); lat = 1;
    wait_idle();
    chk("add_result", 32'(seen_res), 32'h0046);
    chk("add_err", 32'(seen_err), 32'(0));
    chk("add_who", 32'(seen_who), 32'(0));
    chk("add_latency", 32'(seen_cyc - acc_cyc), 32'(3));
    chk("add_start_cycles", 32'(start_seen), 32'(2));
    chk("add_busy_cycles", 32'(busy_seen), 32'(3 + DRAIN));

    // mul FF*FF on requester 1 with done noise after start drops
    issue(1, 8'hFF, 8'hFF, 3'd4); lat = 4; noise_en = 1;
    wait_idle();
    noise_en = 0;
    chk("mul_result", 32'(seen_res), 32'h0000FE01);
    chk("mul_latency", 32'(seen_cyc - acc_cyc), 32'(6));
    chk("mul_rsp_count", 32'(rsp_count), 32'(1));
    chk("mul_who", 32'(seen_who), 32'(1));

    // both requesters, three xors each: grants must alternate
    dut_grants.delete();
    issue(0, 8'hF0, 8'h0F, 3'd3); issue(1, 8'hF0, 8'h0F, 3'd3); lat = 1;
    rem[0] = 2; rem[1] = 2;
    for (int k = 0; k < 300 && (rem[0] + rem[1] > 0); k++) begin
      step();
      for (int r = 0; r < 2; r++)
        if (!pv[r] && rem[r] > 0) begin pv[r] = 1'b1; rem[r]--; end
    end
    wait_idle();
    chk("xor_grant_count", 32'(dut_grants.size()), 32'(6));
    for (int i = 0; i < dut_grants.size(); i++) chk("xor_grant_order", 32'(dut_grants[i]), 32'(i % 2));
    chk("xor_rsp_count", 32'(rsp_count), 32'(6));
    chk("xor_result", 32'(seen_res), 32'h00FF);

    // no_op then illegal op: answered locally next cycle, ALU untouched
    issue(0, 8'h55, 8'h66, 3'd0);
    wait_idle();
    chk("noop_latency", 32'(seen_cyc - acc_cyc), 32'(1));
    chk("noop_result", 32'(seen_res), 32'(0));
    chk("noop_err", 32'(seen_err), 32'(0));
    chk("noop_start", 32'(start_seen), 32'(0));
    issue(0, 8'h55, 8'h66, 3'd6);
    wait_idle();
    chk("illegal_latency", 32'(seen_cyc - acc_cyc), 32'(1));
    chk("illegal_result", 32'(seen_res), 32'(0));
    chk("illegal_err", 32'(seen_err), 32'(1));
    chk("illegal_start", 32'(start_seen), 32'(0));

    // hung ALU: watchdog abort, then a normal command still works
    issue(1, 8'h01, 8'h01, 3'd2); lat = 1000;
    wait_idle();
    chk("timeout_start_cycles", 32'(start_seen), 32'(TIMEOUT));
    chk("timeout_err", 32'(seen_err), 32'(1));
    chk("timeout_result", 32'(seen_res), 32'(0));
    chk("timeout_who", 32'(seen_who), 32'(1));
    issue(0, 8'h01, 8'h01, 3'd1); lat = 1;
    wait_idle();
    chk("post_timeout_result", 32'(seen_res), 32'h0002);

    // reset in the middle of a multiply
    issue(0, 8'h0F, 8'h0E, 3'd4); lat = 4;
    step();
    t0 = acc_cyc;
    while (cyc < t0 + 2) step();
    @(negedge clk); cyc++;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_alu_start", 32'(alu_start), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'(0));
    chk("rst_alu_ab", 32'({alu_a, alu_b}), 32'(0));
    chk("rst_alu_op", 32'(alu_op), 32'(0));
    chk("rst_rsp_data", 32'({rsp0_result, rsp1_result}), 32'(0));
    chk("rst_rsp_err", 32'({rsp0_err, rsp1_err}), 32'(0));
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'(0));
    model_reset();
    @(negedge clk); cyc++;
    @(negedge clk); cyc++;
    #2 reset_n = 1'b1;
    rsp_count = 0;
    repeat (12) step();
    chk("rst_no_stale_rsp", 32'(rsp_count), 32'(0));
    issue(0, 8'h01, 8'h01, 3'd1); lat = 1;
    wait_idle();
    chk("rst_add_result", 32'(seen_res), 32'h0002);
    chk("rst_add_who", 32'(seen_who), 32'(0));

    // randomized traffic with random ALU latencies and done noise
    auto_gen = 1; auto_lat = 1; noise_en = 1;
    repeat (3000) step();
    auto_gen = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/tinyalu_arbiter.md
Name: tinyalu_arbiter

Overview:
- Shares one tinyalu instance between two requesters, each with a valid/ready command port and a per-requester response pulse.
- Arbitrates round-robin and drives the ALU's A/B/op/start.
- Holds start until done, then drains the ALU's done pipeline before the next issue.
- Answers no_op and illegal ops locally, and aborts a hung operation via a watchdog.
- Sits between the testbench/CPU-side requesters and the tinyalu datapath.

Parameters:
- DRAIN, 4: cycles start is held low after an operation, with alu_done ignored. Minimum 4, which covers the multiplier's done3/done2/done1 re-pulse.
- TIMEOUT, 16: cycles alu_start may be held high without alu_done before abort. Minimum 6.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_a  in  8  operand A
- req0_b  in  8  operand B
- req0_op  in  3  operation
- rsp0_valid  out  1  one-cycle response pulse to requester 0
- rsp0_result  out  16  result, valid with rsp0_valid
- rsp0_err  out  1  illegal op or timeout, valid with rsp0_valid
- req1_valid, req1_ready, req1_a, req1_b, req1_op, rsp1_valid, rsp1_result, rsp1_err: same as requester 0
- alu_a  out  8  ALU operand A
- alu_b  out  8  ALU operand B
- alu_op  out  3  ALU op
- alu_start  out  1  ALU start
- alu_done  in  1  ALU done
- alu_result  in  16  ALU result
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - State IDLE; all outputs 0; rr pointer selects requester 0 first; counters cleared.
  - After reset release, no response is produced for an interrupted operation.
- Ops:
  - 0 no_op, 1 add, 2 and, 3 xor, 4 mul. 5..7 are illegal.
- Handshake:
  - reqN_ready may be high only in IDLE, and only for the granted requester.
  - Grant is combinational from the valid inputs and the rr pointer. When both are valid, the requester not granted last wins.
  - A command is accepted on the edge where valid&ready. The requester must hold valid and payload stable until accepted.
  - The rr pointer updates only on acceptance.
- State machine (IDLE, ISSUE, RESP, DRAIN):
  - IDLE, on accept of op 1..4: register a/b/op into alu_a/b/op; alu_start=1 from the next cycle; go to ISSUE.
  - IDLE, on accept of op 0: go to RESP with result 0, err 0. The ALU is not touched.
  - IDLE, on accept of op 5..7: go to RESP with result 0, err 1. The ALU is not touched.
  - ISSUE: alu_start=1; the timeout counter increments each cycle.
    - On alu_done=1: capture alu_result, clear alu_start, go to RESP.
    - On counter == TIMEOUT-1 with no done: result 0, err 1, clear alu_start, go to RESP.
  - RESP: assert the granted requester's rsp valid for exactly 1 cycle, with result and err.
    - Next state is DRAIN if the ALU was issued, else IDLE.
  - DRAIN: alu_start=0; alu_a/b/op hold their values; alu_done is ignored.
    - After DRAIN cycles, set alu_op=0 and go to IDLE.
- Latency from the accept edge at the end of cycle T:
  - add/and/xor: alu_start high in T+1, alu_done in T+2, rsp in T+3, next accept no earlier than T+3+DRAIN.
  - mul: alu_done in T+5, rsp in T+6.
  - no_op/illegal: rsp in T+1, next accept possible in T+2.
- Simultaneous events:
  - alu_done and timeout in the same cycle: done wins (err 0).
  - New valid while busy is not accepted (ready=0).
  - Only one response is ever outstanding.
- Widths: results are passed through unmodified at 16 bits. No arithmetic is performed in the block except the counters.

Decomposition:
- Package tinyalu_ctrl_pkg holds:
  - operation_t enum (no_op=3'b000, add_op, and_op, xor_op, mul_op=3'b100)
  - state_t enum (IDLE, ISSUE, RESP, DRAIN)
  - the is_legal_op function
- One sub-module, rr_arb2: two-request round-robin arbiter with a grant-update input, owning the pointer.

Test Plan:
- req0 add A=8'h12 B=8'h34 -> alu_start T+1..T+2, rsp0_valid at T+3, rsp0_result=16'h0046, err=0; busy high T+1..T+3+DRAIN.
- req1 mul A=8'hFF B=8'hFF -> rsp1_result=16'hFE01 at T+6. Exactly one rsp pulse, despite the multiplier's repeated done pulses during DRAIN.
- Both valid, 3 back-to-back commands each (xor 8'hF0^8'h0F=16'h00FF) -> grants alternate 0,1,0,1,0,1, with no two consecutive grants to the same requester.
- req0 op=3'b000, then req0 op=3'b110 -> rsp at T+1 result 0 err 0, then result 0 err 1; alu_start never asserted.
- alu_done tied 0, req1 and A=1 B=1 -> alu_start high exactly TIMEOUT cycles, rsp1 err=1 result 0, then DRAIN, then IDLE accepts the next command.
- reset_n low mid-mul (T+3) -> all outputs 0 asynchronously. After release, no rsp for the aborted command; a new req0 add 1+1 returns 16'h0002.
